// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: decides each cycle whether slot 0, both slots or
// neither issues, based on a per-register countdown scoreboard, intra-pair
// hazards, the single memory port, control-flow ordering and halt.
// Also counts stall cycles for performance measurement.
module issue_scheduler #(
    parameter int LOAD_LAT = 2,
    parameter int ALU_LAT  = 1,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        s0_valid,
    input  logic [4:0]  s0_src1,
    input  logic [4:0]  s0_src2,
    input  logic        s0_use1,
    input  logic        s0_use2,
    input  logic [4:0]  s0_dst,
    input  logic        s0_we,
    input  logic        s0_is_load,
    input  logic        s0_is_store,
    input  logic        s0_is_ctrl,
    input  logic        s0_is_halt,
    input  logic        s1_valid,
    input  logic [4:0]  s1_src1,
    input  logic [4:0]  s1_src2,
    input  logic        s1_use1,
    input  logic        s1_use2,
    input  logic [4:0]  s1_dst,
    input  logic        s1_we,
    input  logic        s1_is_load,
    input  logic        s1_is_store,
    input  logic        s1_is_ctrl,
    input  logic        s1_is_halt,
    output logic        issue0,
    output logic        issue1,
    output logic        stall,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] ALU_INIT  = CNT_W'(ALU_LAT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt [32];

    logic s0_ready;
    logic s1_ready;
    logic raw_hazard;
    logic waw_hazard;
    logic mem_conflict;
    logic pair_ok;

    // A control op in the younger slot needs no special treatment, since
    // nothing younger than it is issued in the same cycle.
    logic unused_s1_ctrl;
    assign unused_s1_ctrl = s1_is_ctrl;

    // Entry 0 is held at zero, so x0 always reads as ready.
    assign s0_ready = (!s0_use1 || cnt[s0_src1] == '0) && (!s0_use2 || cnt[s0_src2] == '0);
    assign s1_ready = (!s1_use1 || cnt[s1_src1] == '0) && (!s1_use2 || cnt[s1_src2] == '0);

    assign raw_hazard   = s0_we && (s0_dst != 5'd0) &&
                          ((s1_use1 && s1_src1 == s0_dst) || (s1_use2 && s1_src2 == s0_dst));
    assign waw_hazard   = s0_we && s1_we && (s0_dst != 5'd0) && (s0_dst == s1_dst);
    assign mem_conflict = (s0_is_load || s0_is_store) && (s1_is_load || s1_is_store);
    assign pair_ok      = !raw_hazard && !waw_hazard && !mem_conflict && !s0_is_ctrl && !s0_is_halt;

    // Halt state register; halted is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Issue decision, stall flag and halt transition.
    always_comb begin
        state_d = state_q;
        issue0  = 1'b0;
        issue1  = 1'b0;
        stall   = 1'b0;
        if (rst_n && state_q == RUN && !flush) begin
            issue0 = s0_valid && s0_ready;
            issue1 = issue0 && s1_valid && s1_ready && pair_ok;
            stall  = (s0_valid && !issue0) || (s1_valid && !issue1);
            if ((issue0 && s0_is_halt) || (issue1 && s1_is_halt)) state_d = HALTED;
        end
    end

    assign halted = (state_q == HALTED);

    // Countdown scoreboard: a new writer reloads its entry, otherwise busy entries count down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (r == 0)
                    cnt[r] <= '0;
                else if (issue0 && s0_we && s0_dst == 5'(r))
                    cnt[r] <= s0_is_load ? LOAD_INIT : ALU_INIT;
                else if (issue1 && s1_we && s1_dst == 5'(r))
                    cnt[r] <= s1_is_load ? LOAD_INIT : ALU_INIT;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    // Performance counter of stalled cycles, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     stall_cycles <= 32'd0;
        else if (stall) stall_cycles <= stall_cycles + 32'd1;
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: directed hazard scenarios plus
// randomized instruction pairs, checked against a cycle-timestamp model.
module tb_issue_scheduler;

    localparam int LOAD_LAT = 2;
    localparam int ALU_LAT  = 1;

    typedef struct packed {
        logic       valid;
        logic [4:0] src1;
        logic [4:0] src2;
        logic       use1;
        logic       use2;
        logic [4:0] dst;
        logic       we;
        logic       ld;
        logic       st;
        logic       ctrl;
        logic       halt;
    } instr_t;

    typedef struct packed {
        logic        issue0;
        logic        issue1;
        logic        stall;
        logic        halted;
        logic [31:0] stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    instr_t      in0 = '0;
    instr_t      in1 = '0;
    logic        issue0, issue1, stall, halted;
    logic [31:0] stall_cycles;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: cycle at which each register's value becomes usable.
    int          ready_at [32];
    int          cyc = 0;
    logic        m_halted = 1'b0;
    logic [31:0] m_stalls = 32'd0;

    always #5 clk = ~clk;

    issue_scheduler #(.LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s0_valid(in0.valid), .s0_src1(in0.src1), .s0_src2(in0.src2),
        .s0_use1(in0.use1), .s0_use2(in0.use2), .s0_dst(in0.dst), .s0_we(in0.we),
        .s0_is_load(in0.ld), .s0_is_store(in0.st), .s0_is_ctrl(in0.ctrl), .s0_is_halt(in0.halt),
        .s1_valid(in1.valid), .s1_src1(in1.src1), .s1_src2(in1.src2),
        .s1_use1(in1.use1), .s1_use2(in1.use2), .s1_dst(in1.dst), .s1_we(in1.we),
        .s1_is_load(in1.ld), .s1_is_store(in1.st), .s1_is_ctrl(in1.ctrl), .s1_is_halt(in1.halt),
        .issue0(issue0), .issue1(issue1), .stall(stall),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    function automatic instr_t mk(input logic v, input int dst, input int s1, input logic u1,
                                  input int s2, input logic u2, input logic we,
                                  input logic ld, input logic st, input logic ctrl, input logic halt);
        instr_t i;
        i.valid = v;   i.dst = 5'(dst); i.src1 = 5'(s1); i.use1 = u1;
        i.src2 = 5'(s2); i.use2 = u2; i.we = we; i.ld = ld; i.st = st;
        i.ctrl = ctrl; i.halt = halt;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        int k = $urandom_range(0, 9);
        int d = $urandom_range(0, 7);
        int a = $urandom_range(0, 7);
        int b = $urandom_range(0, 7);
        logic v = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 79) == 0) return mk(v, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        case (k)
            4:       return mk(v, d, a, 1, b, 0, 1, 0, 0, 0, 0);
            5:       return mk(v, d, a, 1, b, 0, 1, 1, 0, 0, 0);
            6:       return mk(v, d, a, 1, b, 1, 0, 0, 1, 0, 0);
            7:       return mk(v, d, a, 1, b, 1, 0, 0, 0, 1, 0);
            8:       return mk(v, d, a, 0, b, 0, 1, 0, 0, 1, 0);
            9:       return mk(v, d, a, 0, b, 0, 1, 0, 0, 0, 0);
            default: return mk(v, d, a, 1, b, 1, 1, 0, 0, 0, 0);
        endcase
    endfunction

    function automatic logic src_ok(input logic u, input logic [4:0] r);
        return !u || r == 5'd0 || cyc >= ready_at[r];
    endfunction

    function automatic logic ops_ready(input instr_t i);
        return src_ok(i.use1, i.src1) && src_ok(i.use2, i.src2);
    endfunction

    // Drive one cycle of inputs, predict the response and advance the model.
    task automatic applyStimulus(input instr_t a, input instr_t b, input logic fl);
        exp_t e;
        logic raw, waw, mem;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in0 = a; in1 = b; flush = fl;
        raw = a.we && a.dst != 0 && ((b.use1 && b.src1 == a.dst) || (b.use2 && b.src2 == a.dst));
        waw = a.we && b.we && a.dst != 0 && a.dst == b.dst;
        mem = (a.ld || a.st) && (b.ld || b.st);
        e.halted = m_halted;
        e.stalls = m_stalls;
        e.issue0 = !m_halted && !fl && a.valid && ops_ready(a);
        e.issue1 = e.issue0 && b.valid && ops_ready(b) && !raw && !waw && !mem && !a.ctrl && !a.halt;
        e.stall  = !m_halted && !fl && ((a.valid && !e.issue0) || (b.valid && !e.issue1));
        exp_q.push_back(e);
        if (e.issue0 && a.we && a.dst != 0) ready_at[a.dst] = cyc + (a.ld ? LOAD_LAT : ALU_LAT);
        if (e.issue1 && b.we && b.dst != 0) ready_at[b.dst] = cyc + (b.ld ? LOAD_LAT : ALU_LAT);
        if (e.stall) m_stalls = m_stalls + 32'd1;
        if ((e.issue0 && a.halt) || (e.issue1 && b.halt)) m_halted = 1'b1;
        cyc++;
    endtask

    // Assert reset mid-cycle with valid slots present; everything must read as cleared.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in0 = rand_instr(); in1 = rand_instr(); flush = 1'b0;
        exp_q.push_back('0);
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        m_halted = 1'b0;
        m_stalls = 32'd0;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor: compare each presented cycle against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("issue0", 32'(issue0), 32'(e.issue0));
            checkOutput("issue1", 32'(issue1), 32'(e.issue1));
            checkOutput("stall", 32'(stall), 32'(e.stall));
            checkOutput("halted", 32'(halted), 32'(e.halted));
            checkOutput("stall_cycles", stall_cycles, e.stalls);
        end
    end

    instr_t nop;
    int halt_wait = 0;

    initial begin
        nop = '0;
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        doReset();
        // Independent pair, then intra-pair RAW followed by the shifted SLT.
        applyStimulus(mk(1, 12, 10, 1, 11, 1, 1, 0, 0, 0, 0), mk(1, 11, 10, 1, 0, 0, 1, 0, 0, 0, 0), 0);
        applyStimulus(mk(1, 12, 10, 1, 11, 1, 1, 0, 0, 0, 0), mk(1, 13, 12, 1, 17, 1, 1, 0, 0, 0, 0), 0);
        applyStimulus(mk(1, 13, 12, 1, 17, 1, 1, 0, 0, 0, 0), nop, 0);
        // Load-use bubble.
        applyStimulus(mk(1, 13, 10, 1, 0, 0, 1, 1, 0, 0, 0), nop, 0);
        applyStimulus(mk(1, 14, 13, 1, 11, 1, 1, 0, 0, 0, 0), nop, 0);
        applyStimulus(mk(1, 14, 13, 1, 11, 1, 1, 0, 0, 0, 0), nop, 0);
        // Memory port and WAW.
        applyStimulus(mk(1, 0, 10, 1, 11, 1, 0, 0, 1, 0, 0), mk(1, 13, 10, 1, 0, 0, 1, 1, 0, 0, 0), 0);
        applyStimulus(mk(1, 15, 11, 1, 0, 0, 1, 0, 0, 0, 0), mk(1, 15, 15, 1, 0, 0, 1, 0, 0, 0, 0), 0);
        // Branch in slot 0 holds slot 1; flush lets a pending load complete.
        applyStimulus(mk(1, 0, 11, 1, 12, 1, 0, 0, 0, 1, 0), mk(1, 16, 1, 1, 2, 1, 1, 0, 0, 0, 0), 0);
        applyStimulus(mk(1, 20, 10, 1, 0, 0, 1, 1, 0, 0, 0), nop, 0);
        applyStimulus(mk(1, 21, 20, 1, 0, 0, 1, 0, 0, 0, 0), mk(1, 22, 1, 1, 2, 1, 1, 0, 0, 0, 0), 1);
        applyStimulus(mk(1, 21, 20, 1, 0, 0, 1, 0, 0, 0, 0), nop, 0);
        // Halt in slot 1, then valid slots are refused.
        applyStimulus(mk(1, 3, 1, 1, 2, 1, 1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0);
        applyStimulus(mk(1, 4, 1, 1, 2, 1, 1, 0, 0, 0, 0), mk(1, 5, 1, 1, 2, 1, 1, 0, 0, 0, 0), 0);
        applyStimulus(mk(1, 4, 1, 1, 2, 1, 1, 0, 0, 0, 0), nop, 0);
        // Reset drops a pending load entry.
        doReset();
        applyStimulus(mk(1, 5, 1, 1, 0, 0, 1, 1, 0, 0, 0), nop, 0);
        doReset();
        applyStimulus(mk(1, 6, 5, 1, 0, 0, 1, 0, 0, 0, 0), nop, 0);
        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 2 || halt_wait > 6) begin
                doReset();
                halt_wait = 0;
            end else begin
                applyStimulus(rand_instr(), rand_instr(), r < 10);
                if (m_halted) halt_wait++;
            end
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
